// File: rtl/fifo_stream_pkg.sv
// Shared constants and parameter-legality helpers for the FIFO stream drain stage.
package fifo_stream_pkg;

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned OCC_W     = 2;
    localparam int unsigned BEAT_W    = 8;
    localparam int unsigned BURST_MAX = 256;

    function automatic bit rd_lat_ok(input int unsigned lat);
        return (lat == 0) || (lat == 1);
    endfunction

    function automatic bit burst_ok(input int unsigned burst);
        return (burst >= 1) && (burst <= BURST_MAX);
    endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry in-order register buffer with push, pop and occupancy; head drives the output.
module stream_buf2
    import fifo_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 64
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [OCC_W-1:0] o_occ
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [OCC_W-1:0] r_occ;
    logic             r_valid;
    logic             w_pop;
    logic [OCC_W-1:0] w_occ_nxt;

    assign w_pop     = i_pop & (r_occ != '0);
    assign w_occ_nxt = r_occ + OCC_W'(i_push) - OCC_W'(w_pop);

    // Head keeps its last value when the buffer drains, so the output data holds while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_occ   <= '0;
            r_valid <= 1'b0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_occ == '0) r_head <= i_data;
                    else             r_tail <= i_data;
                end
                2'b01: begin
                    if (r_occ == OCC_W'(2)) r_head <= r_tail;
                end
                2'b11: begin
                    if (r_occ == OCC_W'(1)) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: ;
            endcase
            r_occ   <= w_occ_nxt;
            r_valid <= (w_occ_nxt != '0);
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_head;
    assign o_occ   = r_occ;

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a FIFO read port onto a valid/ready stream with credit-based pops,
// read-latency hiding and fixed-length burst framing.
module fifo_stream_drain
    import fifo_stream_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned BURST  = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_pop,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [OCC_W-1:0] occupancy
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);

    generate
        if (!rd_lat_ok(RD_LAT) || !burst_ok(BURST)) begin : g_bad_param
            $error("fifo_stream_drain: RD_LAT must be 0 or 1 and BURST must be 1..256");
        end
    endgenerate

    logic              w_inflight;
    logic              w_capture;
    logic              w_deq;
    logic [2:0]        w_credit_used;
    logic [2:0]        w_credit_lim;
    logic              w_buf_valid;
    logic [WIDTH-1:0]  w_buf_data;
    logic [OCC_W-1:0]  w_occ;
    logic [BEAT_W-1:0] r_beat;

    assign w_deq = w_buf_valid & m_ready;

    // Credit: buffered + in-flight words, less the one leaving this cycle, must stay below depth.
    assign w_credit_used = 3'(w_occ) + 3'(w_inflight);
    assign w_credit_lim  = 3'(BUF_DEPTH) + 3'(w_deq);
    assign fifo_pop      = ~rst & ~fifo_empty & (w_credit_used < w_credit_lim);

    generate
        if (RD_LAT == 1) begin : g_lat1
            logic r_inflight;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_inflight <= 1'b0;
                else     r_inflight <= fifo_pop;
            end

            assign w_inflight = r_inflight;
            assign w_capture  = r_inflight;
        end else begin : g_lat0
            assign w_inflight = 1'b0;
            assign w_capture  = fifo_pop;
        end
    endgenerate

    stream_buf2 #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_capture),
        .i_data  (fifo_data),
        .i_pop   (w_deq),
        .o_valid (w_buf_valid),
        .o_data  (w_buf_data),
        .o_occ   (w_occ)
    );

    // Beat position within the burst; holds across gaps so a burst resumes where it stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat <= '0;
        end else if (w_deq) begin
            r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + BEAT_W'(1);
        end
    end

    assign m_valid   = w_buf_valid;
    assign m_data    = w_buf_data;
    assign m_last    = w_buf_valid & (r_beat == LAST_BEAT);
    assign occupancy = w_occ;

endmodule
